// File: rtl/feature_axi_writer_if.sv
// AXI4 write-only channel bundle (AW, W, B) between the feature writer and DDR.
// The master modport belongs to the writer; the slave modport to the memory side.
interface feature_axi_writer_if #(
  parameter int AXI_DW = 512,
  parameter int AXI_AW = 32
);
  logic [AXI_AW-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [AXI_DW-1:0]   wdata;
  logic [AXI_DW/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/feature_axi_writer.sv
// Writes one frame of stitched HOG feature words to DDR as fixed-length AXI4 INCR bursts,
// pacing the upstream reader with one w_handshake per accepted W beat.
module feature_axi_writer #(
  parameter int AXI_DW      = 512,
  parameter int AXI_AW      = 32,
  parameter int BURST_LEN   = 16,
  parameter int TOTAL_BEATS = 1984
) (
  input  logic              aclk,
  input  logic              arest_n,
  input  logic              start,
  input  logic [AXI_AW-1:0] base_addr,
  input  logic [AXI_DW-1:0] res_data,
  input  logic              res_data_valid,
  output logic              w_handshake,
  output logic              wr_done,
  output logic              busy,
  output logic              err_overflow,
  output logic              err_bresp,
  feature_axi_writer_if.master m_axi
);

  localparam int NUM_BURSTS = TOTAL_BEATS / BURST_LEN;
  localparam int BCW        = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [AXI_AW-1:0] BURST_BYTES = AXI_AW'(BURST_LEN * (AXI_DW / 8));
  localparam logic [7:0]        LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [BCW-1:0]    LAST_BURST  = BCW'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [AXI_AW-1:0]   r_awaddr;
  logic [7:0]          r_beat_cnt;
  logic [BCW-1:0]      r_burst_cnt;
  logic [AXI_DW-1:0]   r_buf_data;
  logic                r_buf_full;
  logic                r_err_overflow;
  logic                r_err_bresp;

  logic w_start;
  logic w_w_hs;
  logic w_b_hs;
  logic w_last_beat;
  logic w_last_burst;
  logic w_load;

  assign w_start      = (r_state == S_IDLE) && start;
  assign w_w_hs       = m_axi.wvalid && m_axi.wready;
  assign w_b_hs       = m_axi.bvalid && m_axi.bready;
  assign w_last_beat  = (r_beat_cnt == LAST_BEAT);
  assign w_last_burst = (r_burst_cnt == LAST_BURST);
  // Words arriving outside a frame are dropped; inside a frame they are held in any state.
  assign w_load       = res_data_valid && (r_state != S_IDLE);

  assign w_handshake   = w_w_hs;
  assign err_overflow  = r_err_overflow;
  assign err_bresp     = r_err_bresp;

  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.awlen   = LAST_BEAT;
  assign m_axi.awsize  = 3'($clog2(AXI_DW / 8));
  assign m_axi.awburst = 2'b01;
  assign m_axi.wdata   = r_buf_data;
  assign m_axi.wstrb   = '1;

  always_ff @(posedge aclk) begin
    if (!arest_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    m_axi.awvalid = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.wlast   = 1'b0;
    m_axi.bready  = 1'b0;
    wr_done       = 1'b0;
    busy          = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = S_ADDR;
      end
      S_ADDR: begin
        m_axi.awvalid = 1'b1;
        if (m_axi.awready) w_state_next = S_DATA;
      end
      S_DATA: begin
        m_axi.wvalid = r_buf_full;
        m_axi.wlast  = w_last_beat;
        if (r_buf_full && m_axi.wready && w_last_beat) w_state_next = S_RESP;
      end
      S_RESP: begin
        m_axi.bready = 1'b1;
        if (m_axi.bvalid) w_state_next = w_last_burst ? S_DONE : S_ADDR;
      end
      S_DONE: begin
        wr_done      = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        busy         = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!arest_n) begin
      r_awaddr       <= '0;
      r_beat_cnt     <= '0;
      r_burst_cnt    <= '0;
      r_buf_data     <= '0;
      r_buf_full     <= 1'b0;
      r_err_overflow <= 1'b0;
      r_err_bresp    <= 1'b0;
    end else begin
      if (w_start) begin
        r_awaddr       <= base_addr;
        r_beat_cnt     <= '0;
        r_burst_cnt    <= '0;
        r_err_overflow <= 1'b0;
        r_err_bresp    <= 1'b0;
      end

      if (w_w_hs) begin
        r_beat_cnt <= w_last_beat ? 8'd0 : r_beat_cnt + 8'd1;
      end

      if ((r_state == S_RESP) && w_b_hs) begin
        if (m_axi.bresp != 2'b00) r_err_bresp <= 1'b1;
        if (!w_last_burst) begin
          r_burst_cnt <= r_burst_cnt + BCW'(1);
          r_awaddr    <= r_awaddr + BURST_BYTES;
        end
      end

      // A beat leaving the buffer frees the slot for a word arriving in the same cycle.
      if (w_load && (!r_buf_full || w_w_hs)) begin
        r_buf_data <= res_data;
        r_buf_full <= 1'b1;
      end else if (w_w_hs) begin
        r_buf_full <= 1'b0;
      end

      if (w_load && r_buf_full && !w_w_hs) r_err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_feature_axi_writer.sv
// Bench for feature_axi_writer: a reader/slave model drives the DUT; a reference model of
// the expected frame (addresses, words, wlast, pacing, done timing) checks what was observed.
module tb_feature_axi_writer;

  localparam int DW    = 512;
  localparam int AW    = 32;
  localparam int BL    = 16;
  localparam int TB    = 32;
  localparam int NB    = TB / BL;
  localparam int BYTES = DW / 8;

  logic          aclk = 1'b0;
  logic          arest_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [DW-1:0] res_data = '0;
  logic          res_data_valid = 1'b0;
  logic          w_handshake, wr_done, busy, err_overflow, err_bresp;

  feature_axi_writer_if #(.AXI_DW(DW), .AXI_AW(AW)) axi ();

  feature_axi_writer #(
    .AXI_DW(DW), .AXI_AW(AW), .BURST_LEN(BL), .TOTAL_BEATS(TB)
  ) dut (
    .aclk(aclk), .arest_n(arest_n), .start(start), .base_addr(base_addr),
    .res_data(res_data), .res_data_valid(res_data_valid),
    .w_handshake(w_handshake), .wr_done(wr_done), .busy(busy),
    .err_overflow(err_overflow), .err_bresp(err_bresp), .m_axi(axi)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int idx);
    logic [DW-1:0] w;
    w = '0;
    for (int j = 0; j < DW / 32; j++) w[j*32 +: 32] = {16'(idx), 16'(j)};
    return w;
  endfunction

  typedef struct {
    int due;
    int idx;
  } rd_t;

  typedef struct {
    logic [AW-1:0] base;
    bit            rnd;
    int            aw_extra;
    int            w0_delay;
    bit            ovf;
    int            bad_burst;
    bit            start_again;
    bit            exp_ovf;
    bit            exp_bresp;
  } scen_t;

  // Observation and model state
  logic [AW-1:0] aw_q[$];
  logic [DW-1:0] wd_q[$];
  bit            wl_q[$];
  int            b_cyc_q[$];
  int            done_cyc_q[$];
  rd_t           rd_q[$];
  rd_t           rd_item;
  int            cyc = 0;
  int            hs_cnt = 0;
  int            b_count = 0;
  int            pending_b = 0;
  bit            rand_mode = 0;
  int            aw_extra = 0;
  int            bad_burst = -1;
  bit            w_hs_f = 0, b_hs_f = 0;
  bit            aw_armed = 0, w_armed = 0, b_armed = 0;
  int            aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  bit            prev_done = 0;
  bit            busy_at_done = 0, busy_after_done = 1;

  // Monitor: handshakes seen at negedge complete at the following posedge
  always @(negedge aclk) begin
    if (arest_n) begin
      chk("w_handshake_eq", w_handshake, axi.wvalid & axi.wready);
      if (axi.awvalid && axi.awready) begin
        aw_q.push_back(axi.awaddr);
        chk("awlen", axi.awlen, 8'(BL - 1));
        chk("awsize", axi.awsize, 3'd6);
        chk("awburst", axi.awburst, 2'b01);
      end
      if (axi.wvalid && axi.wready) begin
        wd_q.push_back(axi.wdata);
        wl_q.push_back(axi.wlast);
        w_hs_f = 1;
        hs_cnt++;
        if (hs_cnt < TB) rd_q.push_back(rd_t'{due: cyc + 5, idx: hs_cnt});
        if (axi.wlast) pending_b++;
      end
      if (axi.bvalid && axi.bready) begin
        b_cyc_q.push_back(cyc);
        b_hs_f = 1;
        pending_b--;
        b_count++;
      end
      if (prev_done) busy_after_done = busy;
      if (wr_done) begin
        done_cyc_q.push_back(cyc);
        busy_at_done = busy;
      end
      prev_done = wr_done;
    end
  end

  // Reader and AXI slave model
  initial begin : slave_and_reader
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    forever begin
      @(posedge aclk);
      cyc++;
      #1;
      res_data_valid = 1'b0;
      if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        rd_item        = rd_q.pop_front();
        res_data       = word_of(rd_item.idx);
        res_data_valid = 1'b1;
      end
      if (!axi.awvalid) begin
        axi.awready = 1'b0;
        aw_armed    = 0;
      end else begin
        if (!aw_armed) begin
          aw_cnt   = (rand_mode ? int'($urandom_range(0, 7)) : 0) + aw_extra;
          aw_extra = 0;
          aw_armed = 1;
        end
        if (aw_cnt == 0) axi.awready = 1'b1;
        else begin axi.awready = 1'b0; aw_cnt--; end
      end
      if (w_hs_f) begin w_hs_f = 0; w_armed = 0; end
      if (!axi.wvalid) begin
        axi.wready = 1'b0;
        w_armed    = 0;
      end else begin
        if (!w_armed) begin
          w_cnt   = rand_mode ? int'($urandom_range(0, 7)) : 0;
          w_armed = 1;
        end
        if (w_cnt == 0) axi.wready = 1'b1;
        else begin axi.wready = 1'b0; w_cnt--; end
      end
      if (b_hs_f) begin b_hs_f = 0; b_armed = 0; end
      if (pending_b <= 0) begin
        axi.bvalid = 1'b0;
        b_armed    = 0;
      end else begin
        if (!b_armed) begin
          b_cnt   = rand_mode ? int'($urandom_range(0, 7)) : 0;
          b_armed = 1;
        end
        axi.bresp = (b_count == bad_burst) ? 2'b10 : 2'b00;
        if (b_cnt == 0) axi.bvalid = 1'b1;
        else begin axi.bvalid = 1'b0; b_cnt--; end
      end
    end
  end

  task automatic clear_model();
    aw_q.delete(); wd_q.delete(); wl_q.delete(); b_cyc_q.delete(); done_cyc_q.delete();
    rd_q.delete();
    hs_cnt = 0; b_count = 0; pending_b = 0;
    busy_at_done = 0; busy_after_done = 1;
  endtask

  task automatic wait_hs(input int n, input string name);
    int t = 0;
    while (hs_cnt < n && t < 3000) begin @(negedge aclk); t++; end
    if (hs_cnt < n) chk(name, 0, 1);
  endtask

  task automatic run_frame(input scen_t s, input int id);
    int t;
    logic [AW-1:0] exp_a;
    clear_model();
    rand_mode = s.rnd;
    aw_extra  = s.aw_extra;
    bad_burst = s.bad_burst;
    @(posedge aclk); #1;
    start     = 1'b1;
    base_addr = s.base;
    rd_q.push_back(rd_t'{due: cyc + s.w0_delay, idx: 0});
    if (s.ovf) rd_q.push_back(rd_t'{due: cyc + s.w0_delay + 1, idx: 99});
    @(posedge aclk); #1;
    start     = 1'b0;
    base_addr = $urandom;
    @(negedge aclk);
    chk($sformatf("s%0d_busy_after_start", id), busy, 1'b1);
    chk($sformatf("s%0d_ovf_cleared", id), err_overflow, 1'b0);
    chk($sformatf("s%0d_bresp_cleared", id), err_bresp, 1'b0);
    if (s.start_again) begin
      wait_hs(3, "start_again_timeout");
      @(posedge aclk); #1;
      start = 1'b1; base_addr = 32'h7777_0000;
      @(posedge aclk); #1;
      start = 1'b0;
    end
    t = 0;
    while (done_cyc_q.size() == 0 && t < 4000) begin @(negedge aclk); t++; end
    if (done_cyc_q.size() == 0) chk($sformatf("s%0d_frame_timeout", id), 0, 1);
    repeat (10) @(negedge aclk);
    chk($sformatf("s%0d_aw_count", id), aw_q.size(), NB);
    for (int i = 0; i < NB && i < aw_q.size(); i++) begin
      exp_a = s.base + AW'(i * BL * BYTES);
      chk($sformatf("s%0d_awaddr%0d", id, i), aw_q[i], exp_a);
    end
    chk($sformatf("s%0d_w_count", id), wd_q.size(), TB);
    chk($sformatf("s%0d_hs_count", id), hs_cnt, TB);
    for (int i = 0; i < TB && i < wd_q.size(); i++) begin
      chk($sformatf("s%0d_wdata%0d", id, i), wd_q[i], word_of(i));
      chk($sformatf("s%0d_wlast%0d", id, i), wl_q[i], (i % BL) == BL - 1);
    end
    chk($sformatf("s%0d_b_count", id), b_cyc_q.size(), NB);
    chk($sformatf("s%0d_done_pulses", id), done_cyc_q.size(), 1);
    if (done_cyc_q.size() > 0 && b_cyc_q.size() > 0)
      chk($sformatf("s%0d_done_after_b", id), done_cyc_q[0], b_cyc_q[b_cyc_q.size()-1] + 1);
    chk($sformatf("s%0d_busy_at_done", id), busy_at_done, 1'b1);
    chk($sformatf("s%0d_busy_after_done", id), busy_after_done, 1'b0);
    chk($sformatf("s%0d_busy_idle", id), busy, 1'b0);
    chk($sformatf("s%0d_err_overflow", id), err_overflow, s.exp_ovf);
    chk($sformatf("s%0d_err_bresp", id), err_bresp, s.exp_bresp);
  endtask

  scen_t tbl[6];

  initial begin : main
    tbl[0] = '{base: 32'h1000_0000, rnd: 0, aw_extra: 0,  w0_delay: 3, ovf: 0, bad_burst: -1,
               start_again: 0, exp_ovf: 0, exp_bresp: 0};
    tbl[1] = '{base: $urandom & 32'hFFFF_F000, rnd: 1, aw_extra: 0, w0_delay: 2, ovf: 0,
               bad_burst: -1, start_again: 0, exp_ovf: 0, exp_bresp: 0};
    tbl[2] = '{base: 32'h3000_0000, rnd: 0, aw_extra: 10, w0_delay: 2, ovf: 0, bad_burst: -1,
               start_again: 0, exp_ovf: 0, exp_bresp: 0};
    tbl[3] = '{base: 32'h4000_0000, rnd: 0, aw_extra: 10, w0_delay: 2, ovf: 1, bad_burst: -1,
               start_again: 0, exp_ovf: 1, exp_bresp: 0};
    tbl[4] = '{base: 32'h5000_0000, rnd: 0, aw_extra: 0,  w0_delay: 3, ovf: 0, bad_burst: 0,
               start_again: 1, exp_ovf: 0, exp_bresp: 1};
    tbl[5] = '{base: 32'hFFFF_FC00, rnd: 1, aw_extra: 0,  w0_delay: 4, ovf: 0, bad_burst: -1,
               start_again: 0, exp_ovf: 0, exp_bresp: 0};

    arest_n = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_awvalid", axi.awvalid, 1'b0);
    chk("rst_wvalid", axi.wvalid, 1'b0);
    chk("rst_bready", axi.bready, 1'b0);
    chk("rst_wr_done", wr_done, 1'b0);
    chk("rst_awaddr", axi.awaddr, 32'h0);
    chk("rst_errs", {err_overflow, err_bresp}, 2'b00);
    @(posedge aclk); #1;
    arest_n = 1'b1;
    repeat (2) @(posedge aclk);

    for (int k = 0; k < 6; k++) run_frame(tbl[k], k);

    // Reset in the middle of the first burst, then a clean frame
    clear_model();
    rand_mode = 0; aw_extra = 0; bad_burst = -1;
    @(posedge aclk); #1;
    start = 1'b1; base_addr = 32'h6000_0000;
    rd_q.push_back(rd_t'{due: cyc + 2, idx: 0});
    @(posedge aclk); #1;
    start = 1'b0;
    wait_hs(7, "reset_beat7_timeout");
    @(posedge aclk); #1;
    arest_n = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk("midrst_awvalid", axi.awvalid, 1'b0);
    chk("midrst_wvalid", axi.wvalid, 1'b0);
    chk("midrst_bready", axi.bready, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_wr_done", wr_done, 1'b0);
    chk("midrst_awaddr", axi.awaddr, 32'h0);
    @(posedge aclk); #1;
    arest_n = 1'b1;
    clear_model();
    repeat (3) @(posedge aclk);
    run_frame('{base: 32'h1000_0000, rnd: 1, aw_extra: 0, w0_delay: 3, ovf: 0, bad_burst: -1,
               start_again: 0, exp_ovf: 0, exp_bresp: 0}, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
